// File: rtl/pwm_multi_shadowed_if.sv
// Register-side bundle for pwm_multi_shadowed.
//   master: drives dvsr, duty, mode, load, pol; observes pwm_out, period_start, load_pending.
//   slave : the PWM block itself.
// R = duty counter resolution (bits), N = channel count.
interface pwm_multi_shadowed_if #(
  parameter int unsigned R = 10,
  parameter int unsigned N = 4
);
  logic [31:0]        dvsr;
  logic [N*(R+1)-1:0] duty;
  logic               mode;
  logic               load;
  logic [N-1:0]       pol;
  logic [N-1:0]       pwm_out;
  logic               period_start;
  logic               load_pending;

  modport master (
    output dvsr, duty, mode, load, pol,
    input  pwm_out, period_start, load_pending
  );

  modport slave (
    input  dvsr, duty, mode, load, pol,
    output pwm_out, period_start, load_pending
  );
endinterface

// File: rtl/pwm_multi_shadowed.sv
// N-channel PWM generator with one shared prescaler and duty counter.
// Duty and mode writes are staged on load and applied only at a period
// boundary, so an output never changes shape mid-period.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - pwm_multi_shadowed_if.slave:
//          dvsr (prescaler divisor, tick every dvsr+1 cycles),
//          duty (N x (R+1) bits, range 0..2^R), mode (0 edge, 1 center),
//          load (stage duty/mode), pol (per-channel inversion, unstaged),
//          pwm_out (registered), period_start (1-cycle pulse when the
//          counter first reads 0 in a period), load_pending.
module pwm_multi_shadowed #(
  parameter int unsigned R = 10,
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pwm_multi_shadowed_if.slave    bus
);

  localparam logic [R-1:0] M = '1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [31:0]        r_q;
  logic [R-1:0]       r_d;
  dir_t               r_dir;
  logic [R-1:0]       w_d_next;
  dir_t               w_dir_next;
  logic               w_tick;
  logic               w_boundary;

  logic [N*(R+1)-1:0] r_active_duty;
  logic [N*(R+1)-1:0] r_staged_duty;
  logic               r_active_mode;
  logic               r_staged_mode;
  logic               r_load_pending;

  logic [N-1:0]       w_raw;
  logic [N-1:0]       r_pwm;
  logic               r_period_start;

  // Prescaler: the >= compare lets a lowered dvsr pull q back to 0 at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_q <= '0;
    else if (r_q >= bus.dvsr) r_q <= '0;
    else                      r_q <= r_q + 32'd1;
  end

  assign w_tick = (r_q == '0);

  // Duty counter state register (only advances on tick).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d   <= '0;
      r_dir <= DIR_UP;
    end else if (w_tick) begin
      r_d   <= w_d_next;
      r_dir <= w_dir_next;
    end
  end

  // Next counter value assuming a tick. Every path that lands on 0 also
  // leaves dir up, so a mode switch at the boundary always restarts upward.
  always_comb begin
    w_d_next   = r_d;
    w_dir_next = r_dir;
    if (!r_active_mode) begin
      w_d_next   = r_d + R'(1);
      w_dir_next = DIR_UP;
    end else begin
      unique case (r_dir)
        DIR_UP: begin
          if (r_d == M) begin
            w_d_next   = M - R'(1);
            w_dir_next = DIR_DOWN;
          end else begin
            w_d_next   = r_d + R'(1);
          end
        end
        DIR_DOWN: begin
          if (r_d <= R'(1)) begin
            w_d_next   = '0;
            w_dir_next = DIR_UP;
          end else begin
            w_d_next   = r_d - R'(1);
          end
        end
        default: begin
          w_d_next   = '0;
          w_dir_next = DIR_UP;
        end
      endcase
    end
  end

  assign w_boundary = w_tick && (w_d_next == '0);

  // Shadow registers. On a load coinciding with a boundary, the old staged
  // values go active and the later non-blocking writes keep the new load
  // staged with load_pending still set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_duty  <= '0;
      r_staged_duty  <= '0;
      r_active_mode  <= 1'b0;
      r_staged_mode  <= 1'b0;
      r_load_pending <= 1'b0;
    end else begin
      if (w_boundary && r_load_pending) begin
        r_active_duty  <= r_staged_duty;
        r_active_mode  <= r_staged_mode;
        r_load_pending <= 1'b0;
      end
      if (bus.load) begin
        r_staged_duty  <= bus.duty;
        r_staged_mode  <= bus.mode;
        r_load_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_raw = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_raw[i] = ({1'b0, r_d} < r_active_duty[i*(R+1) +: (R+1)]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= w_raw ^ bus.pol;
      r_period_start <= w_boundary;
    end
  end

  assign bus.pwm_out      = r_pwm;
  assign bus.period_start = r_period_start;
  assign bus.load_pending = r_load_pending;

endmodule
